// File: rtl/vegeta_weight_loader.sv
// vegeta_weight_loader: streams NUM_ROWS-word weight tiles into the top of a PE column and manages the PE double buffer.
// Optional define VEGETA_WL_LAST_CHECK_EN enables s_last framing checks reported on the sticky err output.
module vegeta_weight_loader #(
    parameter int ALPHA          = 4,
    parameter int BETA           = 4,
    parameter int MUL_DATAWIDTH  = 8,
    parameter int META_DATA_SIZE = 2,
    parameter int NUM_ROWS       = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 s_valid,
    output logic                                                 s_ready,
    input  logic [ALPHA*BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] s_data,
    input  logic                                                 s_last,
    input  logic                                                 buf_release,
    output logic [ALPHA*BETA*(MUL_DATAWIDTH+META_DATA_SIZE)-1:0] weight_out,
    output logic                                                 weight_xfer_out,
    output logic                                                 wb_sel_out,
    output logic                                                 tile_done,
    output logic [1:0]                                           full_bufs,
    output logic                                                 err
);
    localparam int W  = ALPHA*BETA*(MUL_DATAWIDTH+META_DATA_SIZE);
    localparam int CW = $clog2(NUM_ROWS);
    localparam logic [CW-1:0] LAST_ROW = CW'(NUM_ROWS-1);

    typedef enum logic {LOAD, STALL} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  row_cnt_q, row_cnt_d;
    logic [W-1:0]   weight_q, weight_d;
    logic [1:0]     full_q, full_d;
    logic           xfer_q, xfer_d, wb_q, wb_d, done_q, done_d, err_q, err_d;
    logic           accept, last_beat, tile_end;

    always_comb begin
        accept    = s_valid && (state_q == LOAD);
        last_beat = row_cnt_q == LAST_ROW;
        tile_end  = accept && last_beat;
        weight_d  = accept ? s_data : weight_q;
        xfer_d    = accept;
        row_cnt_d = accept ? (last_beat ? '0 : row_cnt_q + 1'b1) : row_cnt_q;
        done_d    = tile_end;
        wb_d      = wb_q ^ tile_end;
        full_d    = full_q;
        if (tile_end && !buf_release)
            full_d = full_q + 2'd1;
        else if (!tile_end && buf_release && full_q != 2'd0)
            full_d = full_q - 2'd1;
        // STALL is only entered with two full buffers, so a release always frees one
        state_d = (state_q == LOAD) ? ((full_d == 2'd2) ? STALL : LOAD)
                                    : (buf_release ? LOAD : STALL);
`ifdef VEGETA_WL_LAST_CHECK_EN
        err_d = err_q | (accept && (s_last != last_beat));
`else
        err_d = err_q & s_last;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            row_cnt_q <= '0;
            weight_q  <= '0;
            full_q    <= 2'd0;
            xfer_q    <= 1'b0;
            wb_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            weight_q  <= weight_d;
            full_q    <= full_d;
            xfer_q    <= xfer_d;
            wb_q      <= wb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign s_ready         = state_q == LOAD;
    assign weight_out      = weight_q;
    assign weight_xfer_out = xfer_q;
    assign wb_sel_out      = wb_q;
    assign tile_done       = done_q;
    assign full_bufs       = full_q;
    assign err             = err_q;
endmodule

// File: tb/tb_vegeta_weight_loader.sv
// tb_vegeta_weight_loader: directed table-driven bench for vegeta_weight_loader with NUM_ROWS=4 and a 10-bit row word.
module tb_vegeta_weight_loader;
    localparam int W = 10;
`ifdef VEGETA_WL_LAST_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, s_valid, s_ready, s_last, buf_release;
    logic         weight_xfer_out, wb_sel_out, tile_done, err;
    logic [W-1:0] s_data, weight_out;
    logic [1:0]   full_bufs;

    always #5 clk = ~clk;

    vegeta_weight_loader #(
        .ALPHA(1), .BETA(1), .MUL_DATAWIDTH(8), .META_DATA_SIZE(2), .NUM_ROWS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .buf_release(buf_release), .weight_out(weight_out),
        .weight_xfer_out(weight_xfer_out), .wb_sel_out(wb_sel_out), .tile_done(tile_done),
        .full_bufs(full_bufs), .err(err)
    );

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         l, r, xf;
        logic [W-1:0] wo;
        logic         td, wb;
        logic [1:0]   fb;
        logic         rdy;
    } vec_t;

    vec_t vt[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [W-1:0] d, input logic l, input logic r,
                                input logic xf, input logic [W-1:0] wo, input logic td,
                                input logic wb, input logic [1:0] fb, input logic rdy);
        vec_t e;
        e.v = v; e.d = d; e.l = l; e.r = r; e.xf = xf; e.wo = wo;
        e.td = td; e.wb = wb; e.fb = fb; e.rdy = rdy;
        vt.push_back(e);
    endfunction

    task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        s_valid = v; s_data = d; s_last = l; buf_release = r;
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_last = 1'b0; buf_release = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic xf, input logic [W-1:0] wo, input logic td,
                             input logic wb, input logic [1:0] fb, input logic rdy, input logic er);
        chk({tag, ".xfer"}, 32'(weight_xfer_out), 32'(xf));
        chk({tag, ".wout"}, 32'(weight_out), 32'(wo));
        chk({tag, ".done"}, 32'(tile_done), 32'(td));
        chk({tag, ".wb"}, 32'(wb_sel_out), 32'(wb));
        chk({tag, ".full"}, 32'(full_bufs), 32'(fb));
        chk({tag, ".ready"}, 32'(s_ready), 32'(rdy));
        chk({tag, ".err"}, 32'(err), 32'(er));
    endtask

    initial begin
        // single tile 0x101..0x104
        add(1, 10'h101, 0, 0, 1, 10'h101, 0, 0, 0, 1);
        add(1, 10'h102, 0, 0, 1, 10'h102, 0, 0, 0, 1);
        add(1, 10'h103, 0, 0, 1, 10'h103, 0, 0, 0, 1);
        add(1, 10'h104, 1, 0, 1, 10'h104, 1, 1, 1, 1);
        // second tile fills both buffers
        add(1, 10'h201, 0, 0, 1, 10'h201, 0, 1, 1, 1);
        add(1, 10'h202, 0, 0, 1, 10'h202, 0, 1, 1, 1);
        add(1, 10'h203, 0, 0, 1, 10'h203, 0, 1, 1, 1);
        add(1, 10'h204, 1, 0, 1, 10'h204, 1, 0, 2, 0);
        for (int i = 0; i < 10; i++) add(1, 10'h301, 0, 0, 0, 10'h204, 0, 0, 2, 0);
        add(1, 10'h301, 0, 1, 0, 10'h204, 0, 0, 1, 1);
        // tile end coinciding with a release
        add(1, 10'h301, 0, 0, 1, 10'h301, 0, 0, 1, 1);
        add(1, 10'h302, 0, 0, 1, 10'h302, 0, 0, 1, 1);
        add(1, 10'h303, 0, 0, 1, 10'h303, 0, 0, 1, 1);
        add(1, 10'h304, 1, 1, 1, 10'h304, 1, 1, 1, 1);
        // valid gaps 1,0,1,0,1,1
        add(1, 10'h401, 0, 0, 1, 10'h401, 0, 1, 1, 1);
        add(0, 10'h3FF, 0, 0, 0, 10'h401, 0, 1, 1, 1);
        add(1, 10'h402, 0, 0, 1, 10'h402, 0, 1, 1, 1);
        add(0, 10'h3FF, 0, 0, 0, 10'h402, 0, 1, 1, 1);
        add(1, 10'h403, 0, 0, 1, 10'h403, 0, 1, 1, 1);
        add(1, 10'h404, 1, 0, 1, 10'h404, 1, 0, 2, 0);
        // drain, then a release with nothing loaded must not underflow
        add(0, 10'h000, 0, 1, 0, 10'h404, 0, 0, 1, 1);
        add(0, 10'h000, 0, 1, 0, 10'h404, 0, 0, 0, 1);
        add(0, 10'h000, 0, 1, 0, 10'h404, 0, 0, 0, 1);

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; buf_release = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 10'h000, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            step(vt[i].v, vt[i].d, vt[i].l, vt[i].r);
            check_all($sformatf("vec%0d", i), vt[i].xf, vt[i].wo, vt[i].td, vt[i].wb, vt[i].fb, vt[i].rdy, 0);
        end

        // asynchronous reset mid-tile discards the partial tile
        step(1, 10'h501, 0, 0);
        step(1, 10'h502, 0, 0);
        check_all("pre_rst", 1, 10'h502, 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        #2;
        check_all("mid_rst", 0, 10'h000, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 10'h601, 0, 0);
        check_all("rs1", 1, 10'h601, 0, 0, 0, 1, 0);
        step(1, 10'h602, 0, 0);
        check_all("rs2", 1, 10'h602, 0, 0, 0, 1, 0);
        step(1, 10'h603, 0, 0);
        check_all("rs3", 1, 10'h603, 0, 0, 0, 1, 0);
        step(1, 10'h604, 1, 0);
        check_all("rs4", 1, 10'h604, 1, 1, 1, 1, 0);
        step(0, 10'h000, 0, 0);
        check_all("rs_idle", 0, 10'h604, 0, 1, 1, 1, 0);

        // early s_last on beat 2 of a tile
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 10'h701, 0, 0);
        check_all("last1", 1, 10'h701, 0, 0, 0, 1, 0);
        step(1, 10'h702, 1, 0);
        check_all("last2", 1, 10'h702, 0, 0, 0, 1, ERR_EXP);
        step(1, 10'h703, 0, 0);
        check_all("last3", 1, 10'h703, 0, 0, 0, 1, ERR_EXP);
        step(1, 10'h704, 1, 0);
        check_all("last4", 1, 10'h704, 1, 1, 1, 1, ERR_EXP);
        step(0, 10'h000, 0, 0);
        check_all("last_idle", 0, 10'h704, 0, 1, 1, 1, ERR_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
